serial_branchcomp: RTL and testbench
====================================

SERIAL_BRANCHCOMP -- requirements
Module: serial_branchcomp

Interface
REQ-001 Parameter XLEN, default 32, operand width in bits.
REQ-002 Parameter CHUNK, default 8, bits compared per cycle; XLEN SHALL be an integer multiple of CHUNK; NCHUNK = XLEN/CHUNK.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 rdata1  input  XLEN  operand A.
REQ-008 rdata2  input  XLEN  operand B.
REQ-009 funct3  input  3  RISC-V branch funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 br_eq  output  1  A == B.
REQ-013 br_lt  output  1  A < B, signed when funct3[1]=0, unsigned when funct3[1]=1.
REQ-014 br_taken  output  1  branch decision for funct3.

Function
REQ-015 FSM states SHALL be IDLE, CMP, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: on in_valid&in_ready, latch rdata1, rdata2, funct3; chunk index := NCHUNK-1; clear difference flag; go CMP.
REQ-017 CMP: each cycle compare chunk[idx] of A and B, MSB chunk first; for the top chunk in signed mode the chunk MSBs SHALL be inverted before compare (sign bias).
REQ-018 First chunk with A!=B SHALL set diff flag and lt := (chunk A < chunk B); later chunks SHALL NOT alter lt once diff set.
REQ-019 When idx==0 is processed (or early exit, REQ-031) go DONE; br_eq := !diff; br_lt := diff & lt.
REQ-020 br_taken: 000 eq; 001 !eq; 100/110 lt; 101/111 !lt; funct3 010/011 SHALL give br_taken=0 with br_eq/br_lt still computed.
REQ-021 DONE: out_valid=1; br_eq, br_lt, br_taken SHALL hold stable until out_valid&out_ready, then go IDLE next cycle.
REQ-022 No new request SHALL be accepted in the DONE→IDLE handshake cycle; in_ready rises the cycle after.
REQ-023 Latency (accept edge to out_valid) SHALL be NCHUNK cycles without early exit.
REQ-024 Operands on rdata1/rdata2 after acceptance SHALL NOT affect the in-flight result.
REQ-025 Outputs br_eq/br_lt/br_taken SHALL be 0 whenever out_valid=0.

Reset
REQ-026 rst high SHALL force state IDLE, out_valid=0, br_eq=br_lt=br_taken=0, diff=0, idx=0 immediately, independent of clk.
REQ-027 in_ready SHALL be 0 while rst is high and 1 on the first clk edge after release.
REQ-028 rst asserted in CMP or DONE SHALL abort the operation; no out_valid for it SHALL ever appear.

Configuration
REQ-029 Macro SERIAL_BRANCHCOMP_EARLY_EXIT_EN selects early termination.
REQ-030 Without it: always NCHUNK CMP cycles.
REQ-031 With it: CMP SHALL go DONE in the cycle the first differing chunk is found; latency = (NCHUNK - idx_first_diff) cycles, NCHUNK if equal; results identical to the non-early build.

Structure
REQ-032 Package brcmp_pkg SHALL hold funct3 branch encodings and the FSM state typedef.
REQ-033 Sub-module brcmp_chunk (combinational, CHUNK wide, sign-bias input, outputs eq/lt) SHALL be instantiated once.

Verification (XLEN=32, CHUNK=8)
REQ-034 BEQ 0x12345678 vs 0x12345678 -> out_valid 4 cycles after accept, br_eq=1, br_lt=0, br_taken=1.
REQ-035 BLT 0xFFFFFFFF vs 0x00000001 -> br_lt=1, br_taken=1; latency 1 with EARLY_EXIT_EN, 4 without.
REQ-036 BLTU 0xFFFFFFFF vs 0x00000001 -> br_lt=0, br_eq=0, br_taken=0.
REQ-037 BGE 0x00000100 vs 0x00000001 -> br_lt=0, br_taken=1; latency 3 with EARLY_EXIT_EN.
REQ-038 out_ready low 5 cycles in DONE -> outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-039 rst pulse during CMP -> out_valid stays 0, in_ready=1 on first edge after release, next request completes correctly.

Source files
------------

// File: rtl/brcmp_pkg.sv
// Shared definitions for the serial branch comparator.
// Contents: RISC-V branch funct3 encodings, FSM state type, result payload
// struct and the funct3 -> branch-taken decode helper.
package brcmp_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic eq;
        logic lt;
        logic taken;
    } br_res_t;

    // Branch decision; reserved encodings (010/011) never take the branch.
    function automatic logic branch_taken(input logic [2:0] f3,
                                          input logic       eq,
                                          input logic       lt);
        logic tk;
        case (f3)
            F3_BEQ:           tk = eq;
            F3_BNE:           tk = !eq;
            F3_BLT, F3_BLTU:  tk = lt;
            F3_BGE, F3_BGEU:  tk = !lt;
            default:          tk = 1'b0;
        endcase
        return tk;
    endfunction

endpackage

// File: rtl/serial_branchcomp_if.sv
// Request/response bus of the serial branch comparator.
// master: issues operands/funct3 and accepts results (testbench / pipeline).
// slave:  the comparator itself.
interface serial_branchcomp_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [2:0]      funct3;
    logic            out_valid;
    logic            out_ready;
    logic            br_eq;
    logic            br_lt;
    logic            br_taken;

    modport master (
        output in_valid, rdata1, rdata2, funct3, out_ready,
        input  in_ready, out_valid, br_eq, br_lt, br_taken
    );

    modport slave (
        input  in_valid, rdata1, rdata2, funct3, out_ready,
        output in_ready, out_valid, br_eq, br_lt, br_taken
    );
endinterface

// File: rtl/brcmp_chunk.sv
// Combinational CHUNK-wide magnitude comparator.
// Ports: a_i/b_i chunk operands, sign_bias_i flips both MSBs so an unsigned
// compare yields the two's-complement ordering; eq_c/lt_c results.
module brcmp_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             sign_bias_i,
    output logic             eq_c,
    output logic             lt_c
);
    localparam logic [CHUNK-1:0] MSB_MASK = CHUNK'(1) << (CHUNK - 1);

    logic [CHUNK-1:0] a_b;
    logic [CHUNK-1:0] b_b;

    always_comb begin
        a_b  = a_i ^ (sign_bias_i ? MSB_MASK : '0);
        b_b  = b_i ^ (sign_bias_i ? MSB_MASK : '0);
        eq_c = (a_i == b_i);
        lt_c = (a_b < b_b);
    end
endmodule

// File: rtl/serial_branchcomp.sv
// Serial RISC-V branch comparator: compares two XLEN operands CHUNK bits per
// cycle, most significant chunk first, and returns eq / lt / taken.
// Ports: clk, rst (async, active-high), bus (serial_branchcomp_if.slave:
// in_valid/in_ready request, rdata1/rdata2/funct3 operands, out_valid/
// out_ready response, br_eq/br_lt/br_taken results).
// Build option: define SERIAL_BRANCHCOMP_EARLY_EXIT_EN to finish as soon as
// the first differing chunk is seen.
module serial_branchcomp
    import brcmp_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CHUNK = 8
) (
    input logic                clk,
    input logic                rst,
    serial_branchcomp_if.slave bus
);
    localparam int unsigned      NCHUNK  = XLEN / CHUNK;
    localparam int unsigned      IDXW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  IDX_TOP = IDXW'(NCHUNK - 1);

    state_t          state_q, state_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [2:0]      f3_q, f3_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            diff_q, diff_d;
    logic            lt_q, lt_d;
    br_res_t         res_q, res_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    logic [31:0]      shamt_c;
    logic [CHUNK-1:0] a_chunk_c;
    logic [CHUNK-1:0] b_chunk_c;
    logic             sign_bias_c;
    logic             chunk_eq_c;
    logic             chunk_lt_c;
    logic             diff_now_c;
    logic             lt_now_c;
    logic             last_c;

    // Select the chunk under comparison; bias only the sign-carrying top chunk
    // of a signed compare.
    always_comb begin
        shamt_c     = 32'(idx_q) * 32'(CHUNK);
        a_chunk_c   = CHUNK'(a_q >> shamt_c);
        b_chunk_c   = CHUNK'(b_q >> shamt_c);
        sign_bias_c = (idx_q == IDX_TOP) && !f3_q[1];
    end

    brcmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i         (a_chunk_c),
        .b_i         (b_chunk_c),
        .sign_bias_i (sign_bias_c),
        .eq_c        (chunk_eq_c),
        .lt_c        (chunk_lt_c)
    );

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        f3_d        = f3_q;
        idx_d       = idx_q;
        diff_d      = diff_q;
        lt_d        = lt_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;

        // The first differing chunk (from the top) decides the ordering.
        diff_now_c = diff_q | ~chunk_eq_c;
        lt_now_c   = diff_q ? lt_q : chunk_lt_c;
`ifdef SERIAL_BRANCHCOMP_EARLY_EXIT_EN
        last_c     = (idx_q == '0) || !chunk_eq_c;
`else
        last_c     = (idx_q == '0);
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.rdata1;
                    b_d     = bus.rdata2;
                    f3_d    = bus.funct3;
                    idx_d   = IDX_TOP;
                    diff_d  = 1'b0;
                    lt_d    = 1'b0;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                diff_d = diff_now_c;
                lt_d   = lt_now_c;
                idx_d  = idx_q - IDXW'(1);
                if (last_c) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    res_d.eq    = !diff_now_c;
                    res_d.lt    = diff_now_c & lt_now_c;
                    res_d.taken = branch_taken(f3_q, !diff_now_c,
                                               diff_now_c & lt_now_c);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    res_d       = '0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                res_d       = '0;
            end
        endcase

        // Ready only once IDLE is the registered state, so the handshake
        // cycle out of DONE can never accept a request.
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            f3_q        <= '0;
            idx_q       <= '0;
            diff_q      <= 1'b0;
            lt_q        <= 1'b0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            f3_q        <= f3_d;
            idx_q       <= idx_d;
            diff_q      <= diff_d;
            lt_q        <= lt_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.br_eq     = res_q.eq;
    assign bus.br_lt     = res_q.lt;
    assign bus.br_taken  = res_q.taken;
endmodule

// File: tb/tb_serial_branchcomp.sv
// Self-checking bench for serial_branchcomp (XLEN=32, CHUNK=8): directed
// vector table, hand-written handshake/reset sequences and random operands
// against an arithmetic reference model.
module tb_serial_branchcomp;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned CHUNK  = 8;
    localparam int          NCHUNK = int'(XLEN / CHUNK);
`ifdef SERIAL_BRANCHCOMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    serial_branchcomp_if #(.XLEN(XLEN)) bus_if ();

    serial_branchcomp #(.XLEN(XLEN), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic        eq;
        logic        lt;
        logic        tk;
        int          lat_full;
        int          lat_ee;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic; latency from the highest
    // differing bit position.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] f3, output logic eq,
                                  output logic lt, output logic tk, output int lat);
        logic [31:0] x;
        int          p;
        eq = (a == b);
        if (f3[1]) lt = (a < b);
        else       lt = ($signed(a) < $signed(b));
        case (f3)
            3'b000:         tk = eq;
            3'b001:         tk = !eq;
            3'b100, 3'b110: tk = lt;
            3'b101, 3'b111: tk = !lt;
            default:        tk = 1'b0;
        endcase
        lat = NCHUNK;
        if (EARLY && !eq) begin
            x = a ^ b;
            p = 0;
            for (int i = 0; i < 32; i++) if (x[i]) p = i;
            lat = NCHUNK - p / int'(CHUNK);
        end
    endfunction

    // Issue one request and wait for out_valid; out_ready is left low.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                          output logic eq, output logic lt, output logic tk,
                          output int lat, output bit ok);
        int n;
        bit quiet;
        ok = 1'b1; eq = 1'b0; lt = 1'b0; tk = 1'b0; lat = 0;
        n = 0;
        while (bus_if.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (bus_if.in_ready !== 1'b1) begin
            chk("in_ready_timeout", 64'(bus_if.in_ready), 64'(1));
            ok = 1'b0;
            return;
        end
        bus_if.in_valid = 1'b1;
        bus_if.rdata1   = a;
        bus_if.rdata2   = b;
        bus_if.funct3   = f3;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        bus_if.rdata1   = $urandom;
        bus_if.rdata2   = $urandom;
        bus_if.funct3   = 3'($urandom);
        quiet = 1'b1;
        while (bus_if.out_valid !== 1'b1 && lat < 50) begin
            if ({bus_if.br_eq, bus_if.br_lt, bus_if.br_taken, bus_if.in_ready} !== 4'b0)
                quiet = 1'b0;
            @(posedge clk); #1; lat++;
        end
        chk("busy_outputs_low", 64'(quiet), 64'(1));
        if (bus_if.out_valid !== 1'b1) begin
            chk("out_valid_timeout", 64'(bus_if.out_valid), 64'(1));
            ok = 1'b0;
            return;
        end
        eq = bus_if.br_eq;
        lt = bus_if.br_lt;
        tk = bus_if.br_taken;
    endtask

    task automatic finish_hs();
        chk("done_in_ready_low", 64'(bus_if.in_ready), 64'(0));
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        chk("hs_out_valid_low", 64'(bus_if.out_valid), 64'(0));
        chk("hs_in_ready_high", 64'(bus_if.in_ready), 64'(1));
        chk("hs_results_zero", 64'({bus_if.br_eq, bus_if.br_lt, bus_if.br_taken}), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        eq, lt, tk, meq, mlt, mtk;
        int          lat, mlat, mode;
        bit          ok, steady;
        logic [31:0] a, b;
        logic [2:0]  f3;

        vt[0]  = '{32'h12345678, 32'h12345678, 3'b000, 1'b1, 1'b0, 1'b1, 4, 4};
        vt[1]  = '{32'hFFFFFFFF, 32'h00000001, 3'b100, 1'b0, 1'b1, 1'b1, 4, 1};
        vt[2]  = '{32'hFFFFFFFF, 32'h00000001, 3'b110, 1'b0, 1'b0, 1'b0, 4, 1};
        vt[3]  = '{32'h00000100, 32'h00000001, 3'b101, 1'b0, 1'b0, 1'b1, 4, 3};
        vt[4]  = '{32'h00000005, 32'h00000005, 3'b001, 1'b1, 1'b0, 1'b0, 4, 4};
        vt[5]  = '{32'h00000001, 32'h80000000, 3'b111, 1'b0, 1'b1, 1'b0, 4, 1};
        vt[6]  = '{32'h80000000, 32'h7FFFFFFF, 3'b100, 1'b0, 1'b1, 1'b1, 4, 1};
        vt[7]  = '{32'h00000001, 32'h00000002, 3'b010, 1'b0, 1'b1, 1'b0, 4, 4};
        vt[8]  = '{32'h00000003, 32'h00000003, 3'b011, 1'b1, 1'b0, 1'b0, 4, 4};
        vt[9]  = '{32'h000000FF, 32'h00000001, 3'b100, 1'b0, 1'b0, 1'b0, 4, 4};
        vt[10] = '{32'h12FF0000, 32'h12000000, 3'b101, 1'b0, 1'b0, 1'b1, 4, 2};

        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.rdata1    = '0;
        bus_if.rdata2    = '0;
        bus_if.funct3    = '0;

        // Power-on reset, asynchronous.
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus_if.in_ready), 64'(0));
        chk("rst_out_valid", 64'(bus_if.out_valid), 64'(0));
        chk("rst_results", 64'({bus_if.br_eq, bus_if.br_lt, bus_if.br_taken}), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rel_in_ready_before_edge", 64'(bus_if.in_ready), 64'(0));
        @(posedge clk); #1;
        chk("rel_in_ready_first_edge", 64'(bus_if.in_ready), 64'(1));

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].f3, eq, lt, tk, lat, ok);
            if (ok) begin
                chk($sformatf("vec%0d_eq", i), 64'(eq), 64'(vt[i].eq));
                chk($sformatf("vec%0d_lt", i), 64'(lt), 64'(vt[i].lt));
                chk($sformatf("vec%0d_taken", i), 64'(tk), 64'(vt[i].tk));
                chk($sformatf("vec%0d_latency", i), 64'(lat),
                    64'(EARLY ? vt[i].lat_ee : vt[i].lat_full));
                finish_hs();
            end
        end

        // Back-pressure: results held for 5 cycles with out_ready low.
        run_op(32'hFFFFFFFF, 32'h00000001, 3'b100, eq, lt, tk, lat, ok);
        if (ok) begin
            steady = 1'b1;
            repeat (5) begin
                @(posedge clk); #1;
                if (bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b0 ||
                    {bus_if.br_eq, bus_if.br_lt, bus_if.br_taken} !== {eq, lt, tk})
                    steady = 1'b0;
            end
            chk("stall_stable", 64'(steady), 64'(1));
            chk("stall_result", 64'({eq, lt, tk}), 64'(3'b011));
            finish_hs();
        end

        // Reset in the middle of CMP aborts the operation.
        while (bus_if.in_ready !== 1'b1) begin @(posedge clk); #1; end
        bus_if.in_valid = 1'b1;
        bus_if.rdata1   = 32'hA5A5A5A5;
        bus_if.rdata2   = 32'hA5A5A5A5;
        bus_if.funct3   = 3'b000;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(bus_if.out_valid), 64'(0));
        chk("abort_in_ready", 64'(bus_if.in_ready), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_ready_after_release", 64'(bus_if.in_ready), 64'(1));
        steady = 1'b1;
        repeat (6) begin
            if (bus_if.out_valid !== 1'b0) steady = 1'b0;
            @(posedge clk); #1;
        end
        chk("abort_no_out_valid", 64'(steady), 64'(1));
        run_op(32'h00000100, 32'h00000001, 3'b101, eq, lt, tk, lat, ok);
        if (ok) begin
            chk("post_abort_result", 64'({eq, lt, tk}), 64'(3'b001));
            chk("post_abort_latency", 64'(lat), 64'(EARLY ? 3 : 4));
            finish_hs();
        end

        // Random operands vs. reference model, random consumer stalls.
        for (int n = 0; n < 150; n++) begin
            mode = int'($urandom_range(0, 3));
            a = $urandom;
            case (mode)
                0: b = $urandom;
                1: b = a;
                2: b = a ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
                default: begin
                    case ($urandom_range(0, 4))
                        0: a = 32'h80000000;
                        1: a = 32'h7FFFFFFF;
                        2: a = 32'hFFFFFFFF;
                        3: a = 32'h00000000;
                        default: a = 32'h00000001;
                    endcase
                    b = $urandom_range(0, 1) ? ~a : (a + 32'd1);
                end
            endcase
            f3 = 3'($urandom_range(0, 7));
            model(a, b, f3, meq, mlt, mtk, mlat);
            run_op(a, b, f3, eq, lt, tk, lat, ok);
            if (ok) begin
                chk($sformatf("rnd%0d_eq a=%h b=%h f3=%b", n, a, b, f3), 64'(eq), 64'(meq));
                chk($sformatf("rnd%0d_lt a=%h b=%h f3=%b", n, a, b, f3), 64'(lt), 64'(mlt));
                chk($sformatf("rnd%0d_taken a=%h b=%h f3=%b", n, a, b, f3), 64'(tk), 64'(mtk));
                chk($sformatf("rnd%0d_latency", n), 64'(lat), 64'(mlat));
                steady = 1'b1;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                    if ({bus_if.out_valid, bus_if.br_eq, bus_if.br_lt, bus_if.br_taken} !==
                        {1'b1, meq, mlt, mtk})
                        steady = 1'b0;
                end
                chk($sformatf("rnd%0d_hold", n), 64'(steady), 64'(1));
                finish_hs();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
